// File: rtl/dir_pkg.sv
// Shared definitions for the direction-code stream: code constants, frame size,
// generator FSM states and the code-to-velocity mapping.
package dir_pkg;

    localparam logic [2:0] DIR_H     = 3'd1;
    localparam logic [2:0] DIR_V     = 3'd2;
    localparam logic [2:0] DIR_DOPP  = 3'd3;
    localparam logic [2:0] DIR_DSAME = 3'd4;

    localparam int NPAIR = 120;

    typedef enum logic [1:0] {
        s_COLLECT = 2'd0,
        s_LOAD    = 2'd1,
        s_EMIT_X  = 2'd2,
        s_EMIT_Y  = 2'd3
    } gen_state_t;

    // Returns {vx, vy}; illegal codes map to the null vector.
    function automatic logic [15:0] dir_vec(input logic [2:0] code,
                                            input logic       neg,
                                            input logic [7:0] mag);
        logic [7:0] m;
        logic [7:0] mn;
        m  = neg ? (8'd0 - mag) : mag;
        mn = 8'd0 - m;
        case (code)
            DIR_H:     dir_vec = {m, 8'd0};
            DIR_V:     dir_vec = {8'd0, m};
            DIR_DOPP:  dir_vec = {m, mn};
            DIR_DSAME: dir_vec = {m, m};
            default:   dir_vec = 16'd0;
        endcase
    endfunction

    function automatic logic dir_illegal(input logic [2:0] code);
        return (code == 3'd0) || (code > DIR_DSAME);
    endfunction

endpackage

// File: rtl/dir_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing only when adv is high.
module dir_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    // shift register with feedback from taps 8,6,5,4
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed;
        end else if (adv) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/dir_vector_gen.sv
// Collects a frame of direction codes and serialises it as signed (vx, vy)
// velocity bytes on a valid/ready byte interface.
module dir_vector_gen
    import dir_pkg::*;
#(
    parameter int         NPAIR     = dir_pkg::NPAIR,
    parameter int         MAG       = 100,
    parameter int         RAND_SIGN = 1,
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_dir,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_done,
    output logic       o_err
);

    localparam logic [6:0] LAST_IDX = 7'(NPAIR - 1);
    localparam logic [7:0] MAG8     = 8'(MAG);

    gen_state_t state_r, state_s;
    logic [6:0] cnt_r, cnt_s;
    logic [7:0] data_r, data_s;
    logic       neg_r, neg_s;
    logic       err_r;
    logic [2:0] buf_r [0:NPAIR-1];

    logic       accept_s;
    logic       load_x_s;
    logic       load_y_s;
    logic       done_s;
    logic [6:0] rd_idx_s;
    logic       sign_s;
    logic [15:0] vec_x_s;
    logic [15:0] vec_y_s;
    logic [7:0] lfsr_q_s;
    logic       unused_lfsr_s;

    dir_lfsr8 u_lfsr (
        .clk  (i_clk),
        .rst  (i_rst),
        .adv  (load_x_s),
        .seed (SEED),
        .q    (lfsr_q_s)
    );

    assign unused_lfsr_s = ^lfsr_q_s[7:1];

    assign accept_s = i_valid && (state_r == s_COLLECT);
    assign sign_s   = (RAND_SIGN != 0) && lfsr_q_s[0];
    // vx of the next pair is read one slot ahead when leaving s_EMIT_Y
    assign rd_idx_s = (state_r == s_EMIT_Y) ? (cnt_r + 7'd1) : cnt_r;
    assign vec_x_s  = dir_vec(buf_r[rd_idx_s], sign_s, MAG8);
    // vy reuses the sign latched with vx, since the LFSR has moved on
    assign vec_y_s  = dir_vec(buf_r[cnt_r], neg_r, MAG8);

    // next-state, counter and output-byte selection
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        load_x_s = 1'b0;
        load_y_s = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            s_COLLECT: begin
                if (accept_s) begin
                    if (cnt_r == LAST_IDX) begin
                        cnt_s   = 7'd0;
                        state_s = s_LOAD;
                    end else begin
                        cnt_s = cnt_r + 7'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            s_LOAD: begin
                load_x_s = 1'b1;
                state_s  = s_EMIT_X;
            end
            s_EMIT_X: begin
                if (i_ready) begin
                    load_y_s = 1'b1;
                    state_s  = s_EMIT_Y;
                end else begin
                    state_s = s_EMIT_X;
                end
            end
            s_EMIT_Y: begin
                if (i_ready) begin
                    if (cnt_r == LAST_IDX) begin
                        done_s  = 1'b1;
                        cnt_s   = 7'd0;
                        state_s = s_COLLECT;
                    end else begin
                        load_x_s = 1'b1;
                        cnt_s    = cnt_r + 7'd1;
                        state_s  = s_EMIT_X;
                    end
                end else begin
                    state_s = s_EMIT_Y;
                end
            end
            default: begin
                cnt_s   = 7'd0;
                state_s = s_COLLECT;
            end
        endcase

        data_s = data_r;
        neg_s  = neg_r;
        if (load_x_s) begin
            data_s = vec_x_s[15:8];
            neg_s  = sign_s;
        end else if (load_y_s) begin
            data_s = vec_y_s[7:0];
        end else begin
            data_s = data_r;
        end
    end

    // state, counter, output byte and error pulse registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= s_COLLECT;
            cnt_r   <= 7'd0;
            data_r  <= 8'd0;
            neg_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            data_r  <= data_s;
            neg_r   <= neg_s;
            err_r   <= accept_s && dir_illegal(i_dir);
        end
    end

    // code buffer; deliberately not cleared by reset
    always_ff @(posedge i_clk) begin
        if (accept_s) begin
            buf_r[cnt_r] <= i_dir;
        end
    end

    assign o_ready = (state_r == s_COLLECT);
    assign o_valid = (state_r == s_EMIT_X) || (state_r == s_EMIT_Y);
    assign o_data  = data_r;
    assign o_done  = done_s;
    assign o_err   = err_r;

endmodule

// File: tb/tb_dir_vector_gen.sv
// Directed scoreboard bench: two generators (fixed sign, LFSR sign) run in lock-step.
module tb_dir_vector_gen;

    localparam int MAGV = 100;
    localparam int NP   = 120;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dir;
    logic       in_valid;
    logic       out_ready;

    logic       ready_a, valid_a, done_a, err_a;
    logic       ready_b, valid_b, done_b, err_b;
    logic [7:0] data_a, data_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [2:0] qc [$];
    logic [7:0] lfsr_m;
    logic [7:0] last_vx_b;
    logic [2:0] codes [NP];
    int         hs;

    always #5 clk = ~clk;

    dir_vector_gen #(.NPAIR(NP), .MAG(MAGV), .RAND_SIGN(0), .SEED(8'hA5)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_dir(dir), .i_valid(in_valid), .o_ready(ready_a),
        .o_data(data_a), .o_valid(valid_a), .i_ready(out_ready), .o_done(done_a), .o_err(err_a)
    );

    dir_vector_gen #(.NPAIR(NP), .MAG(MAGV), .RAND_SIGN(1), .SEED(8'hA5)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_dir(dir), .i_valid(in_valid), .o_ready(ready_b),
        .o_data(data_b), .o_valid(valid_b), .i_ready(out_ready), .o_done(done_b), .o_err(err_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_vec(input logic [2:0] c, input logic neg);
        logic [7:0] p;
        logic [7:0] n;
        p = neg ? 8'(-MAGV) : 8'(MAGV);
        n = neg ? 8'(MAGV) : 8'(-MAGV);
        case (c)
            3'd1:    return {p, 8'd0};
            3'd2:    return {8'd0, p};
            3'd3:    return {p, n};
            3'd4:    return {p, p};
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] c);
        return (c == 3'd0) || (c > 3'd4);
    endfunction

    // Detector-side classification of a received pair.
    function automatic logic [2:0] classify(input logic signed [7:0] vx, input logic signed [7:0] vy);
        if (vx != 8'sd0 && vy == 8'sd0) return 3'd1;
        if (vx == 8'sd0 && vy != 8'sd0) return 3'd2;
        if (vx != 8'sd0 && vx == -vy)   return 3'd3;
        if (vx != 8'sd0 && vx == vy)    return 3'd4;
        return 3'd0;
    endfunction

    task automatic push_pair(input logic [2:0] c);
        logic        neg;
        logic [15:0] va;
        logic [15:0] vb;
        neg    = lfsr_m[0];
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        va = model_vec(c, 1'b0);
        vb = model_vec(c, neg);
        qa.push_back(va[15:8]); qa.push_back(va[7:0]);
        qb.push_back(vb[15:8]); qb.push_back(vb[7:0]);
        qc.push_back(c);
    endtask

    task automatic send_frame();
        out_ready = 1'b0;
        for (int i = 0; i < NP; i++) begin
            @(negedge clk);
            chk("o_ready_collect", {7'd0, ready_a & ready_b}, 8'd1);
            if (i > 0) begin
                chk("o_err_a", {7'd0, err_a}, {7'd0, is_illegal(codes[i-1])});
                chk("o_err_b", {7'd0, err_b}, {7'd0, is_illegal(codes[i-1])});
            end
            in_valid = 1'b1;
            dir      = codes[i];
            push_pair(codes[i]);
        end
        @(negedge clk);
        chk("o_err_last", {7'd0, err_a}, {7'd0, is_illegal(codes[NP-1])});
        in_valid = 1'b0;
        chk("load_gap_valid", {7'd0, valid_a | valid_b}, 8'd0);
        chk("load_gap_ready", {7'd0, ready_a | ready_b}, 8'd0);
        @(negedge clk);
        chk("valid_rise", {7'd0, valid_a & valid_b}, 8'd1);
    endtask

    task automatic emit(input bit rnd, input int stop_at);
        int cyc;
        cyc = 0;
        hs  = 0;
        while (hs < stop_at && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (hs < 200);
            dir       = 3'd7;
            #1;
            chk("emit_valid", {6'd0, valid_a, valid_b}, 8'd3);
            chk("emit_ready_low", {6'd0, ready_a, ready_b}, 8'd0);
            chk("emit_err", {6'd0, err_a, err_b}, 8'd0);
            chk("data_a", data_a, qa.size() > 0 ? qa[0] : 8'hxx);
            chk("data_b", data_b, qb.size() > 0 ? qb[0] : 8'hxx);
            if (out_ready) begin
                hs++;
                chk("o_done", {6'd0, done_a, done_b}, (hs == 2*NP) ? 8'd3 : 8'd0);
                if (qa.size() > 0) void'(qa.pop_front());
                if (qb.size() > 0) void'(qb.pop_front());
                if (hs % 2 == 0) begin
                    logic [2:0] c;
                    c = (qc.size() > 0) ? qc.pop_front() : 3'd0;
                    if (!is_illegal(c))
                        chk("loopback_dir", {5'd0, classify(last_vx_b, data_b)}, {5'd0, c});
                end else begin
                    last_vx_b = data_b;
                end
            end else begin
                chk("o_done_stall", {6'd0, done_a, done_b}, 8'd0);
            end
        end
        chk("handshakes", 8'(hs), 8'(stop_at));
        if (stop_at == 2*NP) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("post_frame_ready", {6'd0, ready_a, ready_b}, 8'd3);
            chk("post_frame_valid", {6'd0, valid_a, valid_b}, 8'd0);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_ready", {6'd0, ready_a, ready_b}, 8'd3);
        chk("rst_valid", {6'd0, valid_a, valid_b}, 8'd0);
        chk("rst_done", {6'd0, done_a, done_b}, 8'd0);
        chk("rst_err", {6'd0, err_a, err_b}, 8'd0);
        chk("rst_data_a", data_a, 8'd0);
        chk("rst_data_b", data_b, 8'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; dir = 3'd0; out_ready = 1'b0;
        lfsr_m = 8'hA5; last_vx_b = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        // frame 1: all horizontal, no stalls
        for (int i = 0; i < NP; i++) codes[i] = 3'd1;
        send_frame();
        emit(1'b0, 2*NP);

        // frame 2: vertical and both diagonals first, random backpressure
        for (int i = 0; i < NP; i++) codes[i] = 3'd1;
        codes[0] = 3'd2; codes[1] = 3'd3; codes[2] = 3'd4;
        send_frame();
        emit(1'b1, 2*NP);

        // frame 3: illegal codes at pairs 5 and 6
        for (int i = 0; i < NP; i++) codes[i] = 3'($urandom_range(1, 4));
        codes[5] = 3'd0; codes[6] = 3'd7;
        send_frame();
        emit(1'b0, 2*NP);

        // frames 4-6: random legal codes, loopback classification
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NP; i++) codes[i] = 3'($urandom_range(1, 4));
            send_frame();
            emit(f == 1, 2*NP);
        end

        // reset while byte 57 is on the bus, then a fresh frame
        for (int i = 0; i < NP; i++) codes[i] = 3'($urandom_range(1, 4));
        send_frame();
        emit(1'b0, 57);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        qa.delete(); qb.delete(); qc.delete();
        lfsr_m = 8'hA5;
        for (int i = 0; i < NP; i++) codes[i] = 3'($urandom_range(1, 4));
        send_frame();
        emit(1'b1, 2*NP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
